rct_testio_mlane: RTL

RCT_TESTIO_MLANE -- requirements
Module: rct_testio_mlane

---
 rtl/rct_cfg.sv | 58 +++++
 rtl/testio_lane_shifter.sv | 59 +++++
 rtl/rct_testio_mlane.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/rct_cfg.sv
// Shared field offsets, encodings and beat-count helpers for the multi-lane test I/O bridge.
package rct_cfg;

  localparam int REQ_W         = 87;
  localparam int RESP_W        = 51;
  localparam int REQ_TYPE_LSB  = 84;
  localparam int REQ_TID_LSB   = 68;
  localparam int REQ_ADDR_LSB  = 36;
  localparam int REQ_STRB_LSB  = 32;
  localparam int REQ_DATA_LSB  = 0;
  localparam int RESP_TYPE_LSB = 48;
  localparam int RESP_TID_LSB  = 32;

  localparam logic [2:0] TYPE_WR = 3'd1;

  localparam int FRAME_W    = 69;
  localparam int RD_FRAME_W = 37;

  localparam logic [1:0] MODE_L1 = 2'b00;
  localparam logic [1:0] MODE_L2 = 2'b01;
  localparam logic [1:0] MODE_L4 = 2'b10;
  localparam logic [1:0] MODE_L8 = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_SEND   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_ACK    = 3'd4,
    ST_RDATA  = 3'd5,
    ST_PARITY = 3'd6,
    ST_RESP   = 3'd7
  } state_e;

  function automatic logic [1:0] clamp_mode(input logic [1:0] mode, input logic [1:0] max_code);
    return (mode > max_code) ? max_code : mode;
  endfunction

  // ceil(69/L) for writes, ceil(37/L) for reads
  function automatic logic [6:0] send_beats(input logic [1:0] lcode, input logic is_wr);
    case (lcode)
      MODE_L1: return is_wr ? 7'd69 : 7'd37;
      MODE_L2: return is_wr ? 7'd35 : 7'd19;
      MODE_L4: return is_wr ? 7'd18 : 7'd10;
      default: return is_wr ? 7'd9  : 7'd5;
    endcase
  endfunction

  function automatic logic [6:0] rx_beats(input logic [1:0] lcode);
    case (lcode)
      MODE_L1: return 7'd32;
      MODE_L2: return 7'd16;
      MODE_L4: return 7'd8;
      default: return 7'd4;
    endcase
  endfunction

endpackage

// File: rtl/testio_lane_shifter.sv
// Frame serialiser / read-word deserialiser; moves L = 2**lcode_i bits per beat, LSB first.
module testio_lane_shifter
  import rct_cfg::*;
#(
  parameter int TIO_W = 8
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               load_i,
  input  logic [FRAME_W-1:0] frame_i,
  input  logic               tx_shift_i,
  input  logic               rx_shift_i,
  input  logic [1:0]         lcode_i,
  input  logic [TIO_W-1:0]   lane_i,
  output logic [TIO_W-1:0]   lane_o,
  output logic [31:0]        word_o
);

  logic [FRAME_W-1:0] tx_q, tx_d;
  logic [31:0]        rx_q, rx_d, in_w;
  logic [3:0]         lcnt;
  logic [TIO_W-1:0]   lmask;

  assign lcnt = 4'd1 << lcode_i;

  always_comb begin
    lmask = '0;
    for (int i = 0; i < TIO_W; i++) lmask[i] = (i < int'(lcnt));
  end

  // vacated top bits refill with 1 so beats past the frame end drive 1
  always_comb begin
    tx_d = tx_q;
    if (load_i)          tx_d = frame_i;
    else if (tx_shift_i) tx_d = (tx_q >> lcnt) | ~({FRAME_W{1'b1}} >> lcnt);
  end

  // new lanes enter at the top; after 32/L beats beat k lane i sits at bit k*L+i
  assign in_w = 32'(lane_i & lmask);

  always_comb begin
    rx_d = rx_q;
    if (rx_shift_i) rx_d = (rx_q >> lcnt) | (in_w << (6'd32 - {2'b00, lcnt}));
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tx_q <= '0;
      rx_q <= '0;
    end else begin
      tx_q <= tx_d;
      rx_q <= rx_d;
    end
  end

  assign lane_o = tx_q[TIO_W-1:0];
  assign word_o = rx_q;

endmodule

// File: rtl/rct_testio_mlane.sv
// Memory-request to multi-lane serial test-port bridge with ack, read data, parity and timeout.
// state  | meaning
// IDLE   | lanes idle high, waiting for a request
// START  | active lanes drive 0 for one cycle
// SEND   | request frame shifted out L bits per beat
// WAIT   | lanes released, waiting for device start bit on lane0
// ACK    | lane0: 0 = ack, 1 = nack
// RDATA  | read word shifted in L bits per beat
// PARITY | lane0 carries XOR of the read word
// RESP   | response presented until accepted
module rct_testio_mlane
  import rct_cfg::*;
#(
  parameter int          TIO_W    = 8,
  parameter int          TMO_CYC  = 1024,
  parameter logic [31:0] ERR_DATA = 32'hBADC0DE5
) (
  input  logic              ti_clk_i,
  input  logic              ti_rstn_i,
  input  logic              mem_if_req_valid,
  output logic              mem_if_req_ready,
  input  logic [REQ_W-1:0]  mem_if_req,
  output logic              mem_if_resp_valid,
  input  logic              mem_if_resp_ready,
  output logic [RESP_W-1:0] mem_if_resp,
  input  logic [1:0]        ti_mod_i,
  input  logic [TIO_W-1:0]  ti_dat_i,
  output logic [TIO_W-1:0]  ti_dat_o,
  output logic [TIO_W-1:0]  ti_dat_oen,
  output logic              ti_clk_o,
  output logic              ti_clk_oen,
  input  logic              ti_err_clr_i,
  output logic [2:0]        ti_err_o,
  output logic              ti_int_o
);

  localparam logic [1:0]       MAX_CODE = 2'($clog2(TIO_W));
  localparam int               TMO_W    = $clog2(TMO_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_SAT  = TMO_W'(TMO_CYC);

  state_e             state_q, state_d;
  logic [2:0]         type_q;
  logic [15:0]        tid_q;
  logic [1:0]         lcode_q, live_code, drv_code;
  logic [3:0]         drv_lcnt;
  logic [6:0]         beat_q, beat_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [31:0]        rdata_q, rdata_d, rx_word;
  logic [2:0]         err_q, err_d, err_set;
  logic               accept, is_wr, lane0, par_bad;
  logic [FRAME_W-1:0] frame;
  logic [TIO_W-1:0]   sh_lane, drv_dat, drv_oen, dat_q, oen_q;

  assign accept    = mem_if_req_valid & (state_q == ST_IDLE);
  assign is_wr     = (type_q == TYPE_WR);
  assign lane0     = ti_dat_i[0];
  assign live_code = clamp_mode(ti_mod_i, MAX_CODE);
  assign par_bad   = lane0 != (^rx_word);

  always_comb begin
    frame = '1;
    if (mem_if_req[REQ_TYPE_LSB +: 3] == TYPE_WR)
      frame = {mem_if_req[REQ_DATA_LSB +: 32], mem_if_req[REQ_STRB_LSB +: 4],
               mem_if_req[REQ_ADDR_LSB +: 32], 1'b1};
    else
      frame[RD_FRAME_W-1:0] = {mem_if_req[REQ_STRB_LSB +: 4], mem_if_req[REQ_ADDR_LSB +: 32], 1'b0};
  end

  testio_lane_shifter #(.TIO_W(TIO_W)) u_shifter (
    .clk_i      (ti_clk_i),
    .rstn_i     (ti_rstn_i),
    .load_i     (accept),
    .frame_i    (frame),
    .tx_shift_i (state_q == ST_SEND),
    .rx_shift_i (state_q == ST_RDATA),
    .lcode_i    (lcode_q),
    .lane_i     (ti_dat_i),
    .lane_o     (sh_lane),
    .word_o     (rx_word)
  );

  always_ff @(posedge ti_clk_i or negedge ti_rstn_i) begin
    if (!ti_rstn_i) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    err_set = '0;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_START;
      ST_START: state_d = ST_SEND;
      ST_SEND:  if (beat_q == send_beats(lcode_q, is_wr) - 7'd1) state_d = ST_WAIT;
      ST_WAIT: begin
        if (!lane0) state_d = ST_ACK;
        else if (tmo_q == TMO_LAST) begin
          state_d    = ST_RESP;
          err_set[0] = 1'b1;
          rdata_d    = ERR_DATA;
        end
      end
      ST_ACK: begin
        if (lane0) begin
          state_d    = ST_RESP;
          err_set[1] = 1'b1;
          rdata_d    = ERR_DATA;
        end else if (is_wr) begin
          state_d = ST_RESP;
          rdata_d = 32'h0;
        end else begin
          state_d = ST_RDATA;
        end
      end
      ST_RDATA: if (beat_q == rx_beats(lcode_q) - 7'd1) state_d = ST_PARITY;
      ST_PARITY: begin
        state_d = ST_RESP;
        if (par_bad) begin
          err_set[2] = 1'b1;
          rdata_d    = ERR_DATA;
        end else begin
          rdata_d = rx_word;
        end
      end
      ST_RESP: if (mem_if_resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    beat_d = '0;
    if (state_d == state_q && (state_q == ST_SEND || state_q == ST_RDATA)) beat_d = beat_q + 7'd1;
  end

  // cleared everywhere outside WAIT, so it starts at zero on entry and saturates inside
  always_comb begin
    tmo_d = '0;
    if (state_q == ST_WAIT) tmo_d = (tmo_q == TMO_SAT) ? tmo_q : tmo_q + 1'b1;
  end

  assign err_d = (err_q & ~{3{ti_err_clr_i}}) | err_set;

  always_ff @(posedge ti_clk_i or negedge ti_rstn_i) begin
    if (!ti_rstn_i) begin
      type_q  <= '0;
      tid_q   <= '0;
      lcode_q <= '0;
      beat_q  <= '0;
      tmo_q   <= '0;
      rdata_q <= '0;
      err_q   <= '0;
    end else begin
      if (accept) begin
        type_q  <= mem_if_req[REQ_TYPE_LSB +: 3];
        tid_q   <= mem_if_req[REQ_TID_LSB +: 16];
        lcode_q <= live_code;
      end
      beat_q  <= beat_d;
      tmo_q   <= tmo_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // IDLE follows the live mode; once accepted the captured lane count rules
  assign drv_code = (state_q == ST_IDLE) ? live_code : lcode_q;
  assign drv_lcnt = 4'd1 << drv_code;

  always_comb begin
    drv_dat = '0;
    drv_oen = '1;
    for (int i = 0; i < TIO_W; i++) begin
      if (i < int'(drv_lcnt)) begin
        case (state_q)
          ST_IDLE, ST_RESP: begin
            drv_dat[i] = 1'b1;
            drv_oen[i] = 1'b0;
          end
          ST_START: drv_oen[i] = 1'b0;
          ST_SEND: begin
            drv_dat[i] = sh_lane[i];
            drv_oen[i] = 1'b0;
          end
          default: drv_oen[i] = 1'b1;
        endcase
      end
    end
  end

  always_ff @(negedge ti_clk_i or negedge ti_rstn_i) begin
    if (!ti_rstn_i) begin
      dat_q <= '0;
      oen_q <= '0;
    end else begin
      dat_q <= drv_dat;
      oen_q <= drv_oen;
    end
  end

  assign ti_dat_o          = dat_q;
  assign ti_dat_oen        = oen_q;
  assign ti_clk_o          = ti_clk_i;
  assign ti_clk_oen        = 1'b0;
  assign ti_err_o          = err_q;
  assign ti_int_o          = |err_q;
  assign mem_if_req_ready  = accept & ti_rstn_i;
  assign mem_if_resp_valid = (state_q == ST_RESP);
  assign mem_if_resp       = {type_q, tid_q, mem_if_resp_valid ? rdata_q : 32'hFFFF_FFFF};

endmodule
